// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes the bit clock, word select and data into the clk
// domain, deserializes a stereo frame MSB first, and presents each complete
// left/right pair with a one-clk valid strobe. Short slots raise frame_error
// and force a resync on the next left-slot start.
module i2s_receiver #(
    parameter int DATA_BITS = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bclk,
    input  logic                 lrck,
    input  logic                 sdata,
    output logic                 pcm_valid,
    output logic [DATA_BITS-1:0] l_pcm_data,
    output logic [DATA_BITS-1:0] r_pcm_data,
    output logic                 locked,
    output logic                 frame_error
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        SYNC_WAIT,
        LEFT,
        RIGHT
    } state_t;

    logic bclk_meta, bclk_sync, bclk_prev;
    logic lrck_meta, lrck_s;
    logic sdata_meta, sdata_s;
    logic bclk_rise;

    state_t               state, state_next;
    logic                 lrck_prev;
    logic [CW-1:0]        bit_cnt, cnt_next, cnt_inc;
    logic [DATA_BITS-1:0] l_shift, l_next;
    logic [DATA_BITS-1:0] r_shift, r_next;
    logic                 lrck_change;
    logic                 bit_take;
    logic                 slot_full;
    logic                 deliver;
    logic                 slot_err;

    assign bclk_rise   = bclk_sync & ~bclk_prev;
    assign lrck_change = lrck_s ^ lrck_prev;
    assign bit_take    = (bit_cnt < CNT_FULL);
    assign cnt_inc     = bit_cnt + CW'(1);
    // The change edge still carries the last bit of the slot being closed,
    // so a slot is complete if it will hold DATA_BITS bits after this edge.
    assign slot_full   = (bit_cnt >= CNT_LAST);

    // Two-flop synchronizers for all three pins plus an edge-detect flop on bclk.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_meta  <= 1'b0;
            bclk_sync  <= 1'b0;
            bclk_prev  <= 1'b0;
            lrck_meta  <= 1'b0;
            lrck_s     <= 1'b0;
            sdata_meta <= 1'b0;
            sdata_s    <= 1'b0;
        end else begin
            bclk_meta  <= bclk;
            bclk_sync  <= bclk_meta;
            bclk_prev  <= bclk_sync;
            lrck_meta  <= lrck;
            lrck_s     <= lrck_meta;
            sdata_meta <= sdata;
            sdata_s    <= sdata_meta;
        end
    end

    // Slot sequencing: shift data bits, detect slot boundaries and short slots.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        l_next     = l_shift;
        r_next     = r_shift;
        deliver    = 1'b0;
        slot_err   = 1'b0;
        if (bclk_rise) begin
            case (state)
                SYNC_WAIT: begin
                    if (lrck_change && !lrck_s) begin
                        state_next = LEFT;
                        cnt_next   = '0;
                    end
                end
                LEFT: begin
                    if (bit_take) begin
                        l_next   = {l_shift[DATA_BITS-2:0], sdata_s};
                        cnt_next = cnt_inc;
                    end
                    if (lrck_change) begin
                        cnt_next = '0;
                        if (slot_full) begin
                            state_next = RIGHT;
                        end else begin
                            state_next = SYNC_WAIT;
                            slot_err   = 1'b1;
                        end
                    end
                end
                RIGHT: begin
                    if (bit_take) begin
                        r_next   = {r_shift[DATA_BITS-2:0], sdata_s};
                        cnt_next = cnt_inc;
                        deliver  = (bit_cnt == CNT_LAST);
                    end
                    if (lrck_change) begin
                        cnt_next = '0;
                        if (slot_full) begin
                            state_next = LEFT;
                        end else begin
                            state_next = SYNC_WAIT;
                            slot_err   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = SYNC_WAIT;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // State, counter, shift registers and the lrck history sampled per bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SYNC_WAIT;
            bit_cnt   <= '0;
            l_shift   <= '0;
            r_shift   <= '0;
            lrck_prev <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= cnt_next;
            l_shift <= l_next;
            r_shift <= r_next;
            if (bclk_rise) begin
                lrck_prev <= lrck_s;
            end
        end
    end

    // Output registers: load the stereo pair on the final right bit, track lock.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcm_valid   <= 1'b0;
            frame_error <= 1'b0;
            locked      <= 1'b0;
            l_pcm_data  <= '0;
            r_pcm_data  <= '0;
        end else begin
            pcm_valid   <= deliver;
            frame_error <= slot_err;
            if (deliver) begin
                l_pcm_data <= l_shift;
                r_pcm_data <= r_next;
                locked     <= 1'b1;
            end else if (slot_err) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter: DATA_BITS, 24, sample width captured per channel.
REQ-002 Port: clk  input  1  master clock (49.152 MHz); all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: bclk  input  1  I2S bit clock, asynchronous to clk.
REQ-005 Port: lrck  input  1  I2S word select, asynchronous; 0 = left slot, 1 = right slot.
REQ-006 Port: sdata  input  1  I2S serial data, asynchronous, MSB first.
REQ-007 Port: pcm_valid  output  1  one-clk strobe; new stereo pair on l_pcm_data/r_pcm_data.
REQ-008 Port: l_pcm_data  output  24  left sample, two's complement.
REQ-009 Port: r_pcm_data  output  24  right sample, two's complement.
REQ-010 Port: locked  output  1  high once one complete frame has been delivered without error.
REQ-011 Port: frame_error  output  1  one-clk strobe; slot shorter than DATA_BITS was detected.

Function
REQ-012 The module shall pass bclk, lrck and sdata each through a 2-flop synchronizer, plus one extra bclk flop for edge detection.
REQ-013 The module shall generate internal strobe bclk_rise for one clk when the synchronized bclk goes 0->1; all sampling shall happen only on bclk_rise.
REQ-014 Operation shall be guaranteed for clk/bclk >= 4; behaviour below that ratio is undefined.
REQ-015 On each bclk_rise the module shall sample lrck_s and sdata_s and compare lrck_s with the lrck value sampled on the previous bclk_rise.
REQ-016 Format: standard I2S; the lrck change is seen on the bclk_rise carrying the previous slot's last bit, and the slot MSB arrives on the following bclk_rise.
REQ-017 States: SYNC_WAIT, LEFT, RIGHT; reset state is SYNC_WAIT.
REQ-018 SYNC_WAIT -> LEFT on a detected lrck 1->0 change; bit counter cleared; all other lrck activity in SYNC_WAIT shall be ignored.
REQ-019 In LEFT and RIGHT, while bit counter < DATA_BITS, each bclk_rise shall shift sdata_s into the channel shift register (MSB first) and increment the counter.
REQ-020 Bits after the DATA_BITS-th in a slot (e.g. bits 25-32 of a 64fs frame) shall be ignored.
REQ-021 LEFT -> RIGHT on an lrck 0->1 change when counter == DATA_BITS; RIGHT -> LEFT on an lrck 1->0 change when counter == DATA_BITS; counter cleared on each transition.
REQ-022 When the DATA_BITS-th right bit is shifted on bclk_rise in clk cycle N, l_pcm_data and r_pcm_data shall load the left and right shift registers, pcm_valid shall be 1 in cycle N+1 only, and locked shall set in cycle N+1.
REQ-023 l_pcm_data and r_pcm_data shall hold their values between pcm_valid strobes.
REQ-024 An lrck change in LEFT or RIGHT with counter < DATA_BITS shall cause the following in the next clk: frame_error = 1 for one clk, locked = 0, state = SYNC_WAIT, partial frame discarded, and no pcm_valid.
REQ-025 An lrck 1->0 change with counter < DATA_BITS shall be handled per REQ-024, and the same change shall not be reused as a new left start.
REQ-026 Exactly one pcm_valid per error-free frame; pcm_valid and frame_error shall never be high in the same cycle.
REQ-027 End-to-end latency from the pin bclk rising edge carrying the right-channel DATA_BITS-th bit to pcm_valid shall be <= 5 clk.

Reset
REQ-028 While reset = 1, all outputs shall be 0, state = SYNC_WAIT, and counters, shift registers and synchronizer flops shall be cleared.
REQ-029 Reset asserted mid-frame shall discard the partial frame with no pcm_valid; after release, capture shall start only at the next lrck 1->0 change.

Verification
REQ-030 Reset held 10 clk -> pcm_valid = 0, l_pcm_data = r_pcm_data = 0, locked = 0, frame_error = 0.
REQ-031 64fs I2S stimulus, bclk = clk/4, L = 0x123456, R = 0xABCDEF -> one pcm_valid pulse per frame, l = 0x123456, r = 0xABCDEF, locked = 1, pulse within 5 clk of the right-channel LSB (24th bit) bclk edge.
REQ-032 48fs stimulus (24-bit slots), L = 0x7FFF00, R = 0x8000FF -> l = 0x7FFF00, r = 0x8000FF, one pulse per frame.
REQ-033 64fs stimulus with sdata toggling in slot bits 25-32, L = 0x000001, R = 0xFFFFFF -> outputs unaffected, l = 0x000001, r = 0xFFFFFF.
REQ-034 One frame with 16-bit slots inserted between good frames -> frame_error single pulse, no pcm_valid for that frame, locked 1->0, relock and correct data on the next full frame.
REQ-035 Reset pulsed during the right slot -> no pcm_valid for that frame, outputs 0; the first pcm_valid after release carries the data of the first complete frame that starts after release.
